// File: rtl/rv_pkg.sv
// Shared rv32i/rv64i decode constants and the write-back source select type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB handshake plus the register-file write port and forwarding outputs.
interface wb_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rd;
  logic [XLEN-1:0]  c;
  logic [XLEN-1:0]  d;
  logic [XLEN-1:0]  pc;
  logic             write_n;
  logic [4:0]       wr_rd;
  logic [XLEN-1:0]  data_to_reg;
  logic             fwd_valid;
  logic             misalign;
  logic [CNT_W-1:0] instret;

  modport master (
    output in_valid, hold, opcode, funct3, rd, c, d, pc,
    input  in_ready, write_n, wr_rd, data_to_reg, fwd_valid, misalign, instret
  );

  modport slave (
    input  in_valid, hold, opcode, funct3, rd, c, d, pc,
    output in_ready, write_n, wr_rd, data_to_reg, fwd_valid, misalign, instret
  );
endinterface

// File: rtl/load_ext.sv
// Combinational load aligner: shifts the raw word by the byte offset, then
// sign/zero-extends to the access size and flags offsets not aligned to it.
module load_ext
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OFF_W-1:0] i_off,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [XLEN-1:0]  w_shifted;
  logic [XLEN-1:0]  w_mask;
  logic [OFF_W-1:0] w_align_mask;
  logic             w_sign;
  logic             w_reserved;
  int               w_bits;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    w_bits       = 8;
    w_sign       = 1'b0;
    w_align_mask = '0;
    w_reserved   = 1'b0;
    case (i_funct3)
      F3_LB:  w_sign = w_shifted[7];
      F3_LH:  begin w_bits = 16; w_sign = w_shifted[15]; w_align_mask = OFF_W'(1); end
      F3_LW:  begin w_bits = 32; w_sign = w_shifted[31]; w_align_mask = OFF_W'(3); end
      F3_LBU: w_bits = 8;
      F3_LHU: begin w_bits = 16; w_align_mask = OFF_W'(1); end
      F3_LD: begin
        if (XLEN == 64) begin
          w_bits = XLEN; w_sign = w_shifted[XLEN-1]; w_align_mask = OFF_W'(7);
        end else begin
          w_reserved = 1'b1;
        end
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          w_bits = 32; w_align_mask = OFF_W'(3);
        end else begin
          w_reserved = 1'b1;
        end
      end
      default: w_reserved = 1'b1;
    endcase
  end

  // Shifting all-ones by the full width yields zero, so LD gets an all-ones mask.
  assign w_mask     = ~({XLEN{1'b1}} << w_bits);
  assign o_data     = w_sign ? (w_shifted | ~w_mask) : (w_shifted & w_mask);
  assign o_misalign = w_reserved | (|(i_off & w_align_mask));

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: picks ALU/load/link data, drives the register
// file write port one cycle after acceptance and counts retired instructions.
module wb_stage_pipe
  import rv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 64,
  parameter int ZERO_REG_WRITE = 0
) (
  input  logic          clk,
  input  logic          rst,
  wb_stage_pipe_if.slave bus
);

  localparam int OFF_W = $clog2(XLEN / 8);

  wb_sel_e          w_sel;
  logic             w_we;
  logic [XLEN-1:0]  w_ext_data;
  logic             w_ext_mis;
  logic [XLEN-1:0]  w_data_next;

  logic             r_write_n;
  logic [4:0]       r_wr_rd;
  logic [XLEN-1:0]  r_data;
  logic             r_misalign;
  logic [CNT_W-1:0] r_instret;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_funct3   (bus.funct3),
    .i_off      (bus.c[OFF_W-1:0]),
    .i_word     (bus.d),
    .o_data     (w_ext_data),
    .o_misalign (w_ext_mis)
  );

  assign bus.in_ready = !bus.hold;

  always_comb begin
    w_sel = WB_NONE;
    case (bus.opcode)
      OPC_LOAD:                                w_sel = WB_MEM;
      OPC_JAL, OPC_JALR:                       w_sel = WB_PC4;
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC:   w_sel = WB_ALU;
      OPC_OP32, OPC_OPIMM32:                   w_sel = (XLEN == 64) ? WB_ALU : WB_NONE;
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM,
      OPC_SYSTEM:                              w_sel = WB_NONE;
      default:                                 w_sel = WB_NONE;
    endcase
  end

  assign w_we = (w_sel != WB_NONE) && ((bus.rd != 5'd0) || (ZERO_REG_WRITE != 0));

  always_comb begin
    w_data_next = r_data;
    case (w_sel)
      WB_ALU:  w_data_next = bus.c;
      WB_MEM:  w_data_next = w_ext_data;
      WB_PC4:  w_data_next = bus.pc + XLEN'(4);
      default: w_data_next = r_data;
    endcase
  end

  // Non-writing instructions still retire but leave the write port data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_n  <= 1'b1;
      r_wr_rd    <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_instret  <= '0;
    end else if (!bus.hold) begin
      r_write_n  <= !(bus.in_valid && w_we);
      r_misalign <= bus.in_valid && (w_sel == WB_MEM) && w_ext_mis;
      if (bus.in_valid) begin
        r_instret <= r_instret + 1'b1;
        if (w_sel != WB_NONE) begin
          r_wr_rd <= bus.rd;
          r_data  <= w_data_next;
        end
      end
    end
  end

  assign bus.write_n     = r_write_n;
  assign bus.fwd_valid   = !r_write_n;
  assign bus.wr_rd       = r_wr_rd;
  assign bus.data_to_reg = r_data;
  assign bus.misalign    = r_misalign;
  assign bus.instret     = r_instret;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed and random transactions against a size/offset-arithmetic reference model.
module tb_wb_stage_pipe;
  import rv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_stage_pipe #(.XLEN(XLEN), .CNT_W(CNT_W), .ZERO_REG_WRITE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          m_write_n;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_data;
  bit          m_mis;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = no write, 1 = ALU result, 2 = load, 3 = link address
  function automatic int model_kind(input logic [6:0] opc);
    if (opc == OPC_LOAD) return 2;
    if (opc == OPC_JAL || opc == OPC_JALR) return 3;
    if (opc == OPC_OP || opc == OPC_OPIMM || opc == OPC_LUI || opc == OPC_AUIPC) return 1;
    return 0;
  endfunction

  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] word, input int off);
    longint unsigned w, v;
    int nb;
    bit sgn;
    nb  = model_size(f3);
    sgn = (f3 <= 3'd2) && (nb != 0);
    if (nb == 0) nb = 1;
    w = word;
    v = (w >> (8 * off)) % (64'd1 << (8 * nb));
    if (sgn && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input int off);
    int sz;
    sz = model_size(f3);
    if (sz == 0) return 1'b1;
    return (off % sz) != 0;
  endfunction

  task automatic check_outs();
    check("write_n", bus.write_n, m_write_n);
    check("fwd_valid", bus.fwd_valid, !m_write_n);
    check("misalign", bus.misalign, m_mis);
    check("instret", bus.instret, m_cnt);
    check("wr_rd", bus.wr_rd, m_wr_rd);
    check("data_to_reg", bus.data_to_reg, m_data);
  endtask

  task automatic model_reset();
    m_write_n = 1'b1;
    m_wr_rd   = '0;
    m_data    = '0;
    m_mis     = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic cycle(input bit v, input bit h, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] c, input logic [31:0] d,
                       input logic [31:0] pc);
    int k;
    bus.in_valid = v;
    bus.hold     = h;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.rd       = rd;
    bus.c        = c;
    bus.d        = d;
    bus.pc       = pc;
    #1;
    check("in_ready", bus.in_ready, !h);
    if (!h) begin
      if (v) begin
        m_cnt     = (m_cnt + 1) % (1 << CNT_W);
        k         = model_kind(opc);
        m_write_n = !(k != 0 && rd != 5'd0);
        m_mis     = (k == 2) && model_mis(f3, int'(c[1:0]));
        if (k != 0) begin
          m_wr_rd = rd;
          m_data  = (k == 1) ? c : (k == 2) ? model_load(f3, d, int'(c[1:0])) : pc + 32'd4;
        end
      end else begin
        m_write_n = 1'b1;
        m_mis     = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    $display("txn v=%0b h=%0b opc=%07b f3=%0d rd=%0d c=%08h d=%08h pc=%08h -> wn=%0b rd=%0d data=%08h mis=%0b cnt=%0d",
             v, h, opc, f3, rd, c, d, pc, bus.write_n, bus.wr_rd, bus.data_to_reg, bus.misalign, bus.instret);
    check_outs();
  endtask

  task automatic do_reset(input int cycles, input bit h);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.hold     = h;
    bus.opcode   = OPC_OP;
    bus.rd       = 5'd9;
    bus.c        = 32'h5555_AAAA;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      model_reset();
      $display("txn reset h=%0b -> wn=%0b cnt=%0d", h, bus.write_n, bus.instret);
      check_outs();
    end
    rst = 1'b0;
  endtask

  logic [6:0] opc_tab [12];

  initial begin
    opc_tab = '{OPC_LOAD, OPC_LOAD, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM,
                OPC_LUI, OPC_AUIPC, OPC_STORE, OPC_BRANCH, 7'h7F};
    bus.funct3 = '0;
    bus.d      = '0;
    bus.pc     = '0;
    model_reset();

    do_reset(2, 1'b0);
    cycle(1, 0, OPC_OP,   3'd0,   5'd5, 32'h1234_5678, 32'h0, 32'h0);
    cycle(1, 0, OPC_JAL,  3'd0,   5'd1, 32'h0, 32'h0, 32'hFFFF_FFFC);
    cycle(1, 0, OPC_LOAD, F3_LB,  5'd3, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
    cycle(1, 0, OPC_LOAD, F3_LBU, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
    cycle(1, 0, OPC_LOAD, F3_LH,  5'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    cycle(1, 0, OPC_LOAD, F3_LH,  5'd4, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
    cycle(1, 0, OPC_LOAD, 3'd7,   5'd6, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    cycle(1, 0, OPC_STORE, 3'd2,  5'd4, 32'h0000_2000, 32'h0, 32'h0);
    cycle(1, 0, OPC_OP,   3'd0,   5'd0, 32'h0000_DEAD, 32'h0, 32'h0);
    cycle(0, 0, OPC_OP,   3'd0,   5'd8, 32'h0BAD_0BAD, 32'h0, 32'h0);

    // Stall with a pending instruction, then release it.
    repeat (3) cycle(1, 1, OPC_OP, 3'd0, 5'd7, 32'hAAAA_5555, 32'h0, 32'h0);
    cycle(1, 0, OPC_OP, 3'd0, 5'd7, 32'hAAAA_5555, 32'h0, 32'h0);
    cycle(0, 0, OPC_OP, 3'd0, 5'd7, 32'h0, 32'h0, 32'h0);

    // Reset arriving during a stall discards the held result.
    cycle(1, 1, OPC_JALR, 3'd0, 5'd2, 32'h0, 32'h0, 32'h100);
    do_reset(1, 1'b1);

    // Sixteen transfers wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++)
      cycle(1, 0, OPC_OPIMM, 3'd0, 5'(i + 1), 32'(i * 3), 32'h0, 32'h0);
    check("instret_wrap", bus.instret, 0);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            opc_tab[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Registered, parametrised write-back stage for the rv32i pipeline. It sits between the MEM stage and the register file.
- Accepts one retiring instruction per cycle over a valid/ready handshake.
- Sign/zero-extends and aligns load data by funct3 and byte offset.
- Selects the write-back source and drives the register-file write port one cycle later.
- Exposes the same registered result as a forwarding source and counts retired instructions.

Parameters:
XLEN, 32, datapath width (32 or 64; load extension covers B/H/W, plus D/WU when XLEN=64)
CNT_W, 64, width of retired-instruction counter
ZERO_REG_WRITE, 0, when 0 a write to rd=x0 is suppressed (write_n held 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  MEM presents a retiring instruction
in_ready  out  1  stage can accept; equals !hold
hold  in  1  register file / downstream stall; freezes output registers
opcode  in  7  instruction opcode
funct3  in  3  load size/sign selector
rd  in  5  destination register
c  in  XLEN  ALU result; low bits also used as load address offset
d  in  XLEN  raw memory read word
pc  in  XLEN  instruction PC
write_n  out  1  register-file write enable, active-low
wr_rd  out  5  register-file write index
data_to_reg  out  XLEN  register-file write data
fwd_valid  out  1  registered result valid for forwarding (mirrors !write_n)
misalign  out  1  registered flag: accepted load was misaligned for its size
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at clk edge) sets write_n=1, wr_rd=0, data_to_reg=0, fwd_valid=0, misalign=0, instret=0. Reset dominates hold and in_valid. Reset mid-stall discards the held result.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !hold, combinational; there is no internal buffer.
  - While hold=1 all output registers and instret are frozen; the MEM stage must keep its inputs stable.
- Latency: one cycle. Inputs accepted at edge N appear on the outputs after edge N.
- Cycle with no transfer (in_valid=0, hold=0): write_n→1, fwd_valid→0, misalign→0. data_to_reg and wr_rd retain their previous values.
- Source selection by opcode:
  - LOAD 0000011 → extended load data.
  - JAL 1101111 and JALR 1100111 → pc+4, computed modulo 2^XLEN; wrap from all-ones is legal.
  - OP, OP-IMM, LUI, AUIPC (and their 64-bit W variants when XLEN=64) → c.
  - STORE, BRANCH, MISC-MEM, SYSTEM, unknown opcodes → no write (write_n=1). These are still counted in instret.
- Load extension:
  - Byte offset off = c[log2(XLEN/8)-1:0]; the field is shifted right by 8*off.
  - LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD (XLEN=64) takes the full word.
  - Reserved funct3 values give zero-extended byte data and set misalign=1.
- misalign=1 when off is not a multiple of the access size. Data is still written, computed as the shift above; wrapped bytes are not fetched.
- Write suppression: write_n=1 when rd=0 and ZERO_REG_WRITE=0. In that case data_to_reg still updates.
- instret increments by 1 on every transfer and wraps at 2^CNT_W-1 → 0.

Decomposition:
- Shared package rv_pkg:
  - opcode constants (OPC_LOAD, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_STORE, OPC_BRANCH, OPC_SYSTEM)
  - load funct3 constants
  - 2-bit write-back select enum (WB_ALU, WB_MEM, WB_PC4, WB_NONE)
- Sub-module load_ext (purely combinational, parametrised by XLEN): takes funct3, offset and raw word; produces extended data and the misalign flag.
- Opcode decode stays inline; it is a small case statement.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 → write_n=1, fwd_valid=0, instret=0; first transfer after release → instret=1.
- ALU and jump sources:
  - OP, rd=5, c=0x1234_5678 → next cycle write_n=0, wr_rd=5, data_to_reg=0x1234_5678.
  - JAL with pc=0xFFFF_FFFC → data_to_reg=0x0000_0000.
- Load extension:
  - d=0x80FF_7F01, LB, c[1:0]=3 → 0xFFFF_FF80.
  - LBU, off=3 → 0x0000_0080.
  - LH, off=2 → 0xFFFF_80FF.
  - LH, off=1 → misalign=1.
- Suppression: STORE, or OP with rd=0 → write_n=1, fwd_valid=0, instret still increments.
- Stall: hold=1 for 3 cycles with a new in_valid instruction → in_ready=0, outputs and instret frozen; after release the new result appears one cycle later.
- Counter wrap: with CNT_W=4, perform 16 transfers → instret returns to 0.
